// File: rtl/ca_pipe_pkg.sv
// Shared pipeline definitions: instruction field positions, control bundle layout, helpers.
package ca_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 32;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Layout of the opaque EX/MEM/WB control bundle as produced by the decoder.
    localparam int CTRL_ALU_SRC    = 0;
    localparam int CTRL_ALU_OP_LSB = 1;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 7;

    // A bubble must not write memory or registers, so every control bit is cleared.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_operand_bypass.sv
// Selects one ID operand: $0 forced to zero, then same-cycle WB data, then register file data.
module id_operand_bypass
    import ca_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    // Register 0 is never reset in the file, so its read data is ignored outright.
    always_comb begin
        operand = rf_data;
        if (addr == REG_ZERO) begin
            operand = '0;
        end else if (wb_we && (wb_addr == addr)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use hazard detection and bubble counter.
module id_ex_stage
    import ca_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              memread_i,
    input  logic              regwrite_i,
    input  logic              uses_rt_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic              wb_RegWrite_i,
    input  logic [4:0]        wb_RDaddr_i,
    input  logic [DATA_W-1:0] wb_RDdata_i,
    output logic              hazard_stall_o,
    output logic              ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_memread_o,
    output logic              ex_regwrite_o,
    output logic [DATA_W-1:0] ex_rsdata_o,
    output logic [DATA_W-1:0] ex_rtdata_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_rsdata;
    logic [DATA_W-1:0] id_rtdata;
    logic              unused_opcode;

    assign id_rs  = instr_i[RS_MSB:RS_LSB];
    assign id_rt  = instr_i[RT_MSB:RT_LSB];
    assign id_rd  = instr_i[RD_MSB:RD_LSB];
    assign id_imm = {{(DATA_W-16){instr_i[IMM_MSB]}}, instr_i[IMM_MSB:IMM_LSB]};
    assign unused_opcode = ^instr_i[31:26];

    id_operand_bypass #(.DATA_W(DATA_W)) u_rs_bypass (
        .addr    (id_rs),
        .rf_data (RSdata_i),
        .wb_we   (wb_RegWrite_i),
        .wb_addr (wb_RDaddr_i),
        .wb_data (wb_RDdata_i),
        .operand (id_rsdata)
    );

    id_operand_bypass #(.DATA_W(DATA_W)) u_rt_bypass (
        .addr    (id_rt),
        .rf_data (RTdata_i),
        .wb_we   (wb_RegWrite_i),
        .wb_addr (wb_RDaddr_i),
        .wb_data (wb_RDdata_i),
        .operand (id_rtdata)
    );

    // Load in EX whose destination is a source of the ID instruction; a bubble never matches.
    always_comb begin
        hazard_stall_o = 1'b0;
        if (valid_i && ex_valid_o && ex_memread_o && (ex_rt_o != REG_ZERO)) begin
            hazard_stall_o = (ex_rt_o == id_rs) || (uses_rt_i && (ex_rt_o == id_rt));
        end
    end

    // EX slot update: reset > flush > stall (with WB refresh) > load-use bubble > load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= '0;
            ex_memread_o  <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_rsdata_o   <= '0;
            ex_rtdata_o   <= '0;
            ex_imm_o      <= '0;
            ex_rs_o       <= '0;
            ex_rt_o       <= '0;
            ex_rd_o       <= '0;
            ex_pc_o       <= '0;
            bubble_cnt_o  <= '0;
        end else if (flush_i) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= CTRL_W'(CTRL_BUBBLE);
            ex_memread_o  <= 1'b0;
            ex_regwrite_o <= 1'b0;
        end else if (stall_i) begin
            // Held operands would otherwise miss a write-back that lands during the hold.
            if (wb_RegWrite_i && (wb_RDaddr_i != REG_ZERO) && (wb_RDaddr_i == ex_rs_o)) begin
                ex_rsdata_o <= wb_RDdata_i;
            end
            if (wb_RegWrite_i && (wb_RDaddr_i != REG_ZERO) && (wb_RDaddr_i == ex_rt_o)) begin
                ex_rtdata_o <= wb_RDdata_i;
            end
        end else if (hazard_stall_o) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= CTRL_W'(CTRL_BUBBLE);
            ex_memread_o  <= 1'b0;
            ex_regwrite_o <= 1'b0;
            bubble_cnt_o  <= bubble_cnt_o + 1'b1;
        end else begin
            ex_valid_o    <= valid_i;
            ex_ctrl_o     <= ctrl_i;
            ex_memread_o  <= memread_i;
            ex_regwrite_o <= regwrite_i;
            ex_rsdata_o   <= id_rsdata;
            ex_rtdata_o   <= id_rtdata;
            ex_imm_o      <= id_imm;
            ex_rs_o       <= id_rs;
            ex_rt_o       <= id_rt;
            ex_rd_o       <= id_rd;
            ex_pc_o       <= pc_i;
        end
    end

endmodule
